frame_tx_mii: RTL and testbench
===============================

FRAME_TX_MII -- requirements
Module: frame_tx_mii

Interface
REQ-001 Parameter ADDR_W, default 11: frame-buffer address width.
REQ-002 Parameter IFG_BYTES, default 12: inter-frame gap length in byte times.
REQ-003 Port clk  input  1: the single clock, the MII transmit clock (25 MHz); all logic on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port start  input  1: request to transmit one frame from the buffer.
REQ-006 Port frame_len  input  ADDR_W: byte count held in the buffer, including the 7x 0x55 preamble and the 0xD5 SFD, excluding FCS.
REQ-007 Port ram_addr  output  ADDR_W: frame-buffer read address.
REQ-008 Port ram_dout  input  8: frame-buffer read data, valid one clk after ram_addr.
REQ-009 Port tx_d  output  4: MII TXD nibble.
REQ-010 Port tx_en  output  1: MII TX_EN.
REQ-011 Port busy  output  1: high from start accept until done.
REQ-012 Port done  output  1: one-cycle pulse at the end of the inter-frame gap.
REQ-013 Port err  output  1: one-cycle pulse when a start is rejected.

Function
REQ-014 The block shall implement states IDLE, PREFETCH, DATA, FCS and IFG.
REQ-015 IDLE: start=1 with frame_len in 9..1401 shall be accepted at that edge (cycle T): latch frame_len, set busy=1, go to PREFETCH.
REQ-016 IDLE: start=1 with frame_len outside 9..1401 shall produce err=1 for one cycle and no other change.
REQ-017 start shall be ignored while busy=1.
REQ-018 The first tx_en=1 cycle shall be exactly T+3; PREFETCH shall last until then.
REQ-019 Each buffer byte shall occupy two consecutive cycles: low nibble, then high nibble.
REQ-020 ram_addr shall advance 0,1,...,frame_len-1, one step per byte, so that each byte is present on ram_dout before its low nibble is driven.
REQ-021 tx_en shall stay high without gaps from the first nibble to the last nibble of the frame, FCS included.
REQ-022 The CRC-32 shall use the reflected polynomial 0xEDB88320 with initial value 0xFFFFFFFF, computed over buffer bytes 8..frame_len-1 (the SFD and everything before it are excluded).
REQ-023 FCS state: the complemented CRC shall be sent as 4 bytes, least significant byte first, each byte low nibble first (8 cycles).
REQ-024 IFG state: tx_en=0 and tx_d=0 for exactly 2*IFG_BYTES cycles.
REQ-025 On the final IFG cycle the block shall pulse done=1 and return to IDLE, with busy=0 in the same cycle.
REQ-026 A start present in the cycle after done shall be accepted.
REQ-027 Whenever tx_en=0, tx_d shall be 0.
REQ-028 Arithmetic: the byte counter is ADDR_W bits wide and compares against the latched frame_len; no wrap occurs within the 9..1401 range.

Reset
REQ-029 rst=1 shall, at the next edge and from any state, force: state=IDLE, tx_en=0, tx_d=0, busy=0, done=0, err=0, ram_addr=0, CRC=0xFFFFFFFF.
REQ-030 A reset mid-frame shall truncate the frame immediately; no FCS and no done are produced.
REQ-031 rst shall take priority over start in the same cycle.

Configuration
REQ-032 Macro TX_FCS_EN:
- Defined: the CRC is computed and the FCS state appends 4 bytes.
- Undefined: there is no CRC logic and the FCS state is skipped, so the frame ends after buffer byte frame_len-1 and the buffer must already hold the FCS.
- tx_en high-cycle count is 2*frame_len+8 with the macro defined, 2*frame_len without it.

Verification
REQ-033 Buffer = 7x55, D5, "123456789"; frame_len=17; TX_FCS_EN defined -> 42 tx_en cycles ending with nibbles 6,2,9,3,4,F,B,C (FCS 0xCBF43926).
REQ-034 Same buffer, TX_FCS_EN undefined -> exactly 34 tx_en cycles, last nibbles 9,3, then 24 idle cycles, then done.
REQ-035 start at cycle T -> first tx_en at T+3 with tx_d=5; done exactly 24 cycles after tx_en falls.
REQ-036 start with frame_len=8, or with frame_len=1402 -> err pulse, busy remains 0, tx_en remains 0.
REQ-037 rst pulsed at the 20th tx_en cycle -> tx_en=0 at the next edge, no done; a new start afterwards transmits a correct full frame.
REQ-038 start held high through the whole frame -> exactly one frame transmitted before done; the second frame begins at done+3 cycles.

Source files
------------

// File: rtl/frame_tx_mii.sv
// frame_tx_mii: streams a frame buffer out over an MII transmit nibble bus.
// Each buffer byte is read one clk ahead of use and sent low nibble first,
// followed by an optional CRC-32 FCS and a fixed inter-frame gap.
// Build option: define TX_FCS_EN to compute and append the FCS; without it
// the buffer must already hold the FCS and no CRC logic is built.
module frame_tx_mii #(
  parameter int ADDR_W    = 11,
  parameter int IFG_BYTES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_len,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_dout,
  output logic [3:0]        tx_d,
  output logic              tx_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IFG_CYC = 2 * IFG_BYTES;
  localparam int IFG_W   = $clog2(IFG_CYC + 1);
  localparam logic [ADDR_W-1:0] LEN_MIN = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(1401);
  // The done cycle is itself the last gap cycle, so the IFG state covers one less.
  localparam logic [IFG_W-1:0]  IFG_LAST = IFG_W'(IFG_CYC - 2);

  typedef enum logic [2:0] {IDLE, PREFETCH, DATA, FCS, IFG} state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] len_q, len_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] byte_q, byte_n;
  logic              phase_q, phase_n;   // 0: low nibble on the bus, 1: high nibble
  logic              pf_q, pf_n;
  logic [7:0]        data_q, data_n;
  logic [3:0]        txd_q, txd_n;
  logic              txen_q, txen_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic [IFG_W-1:0]  ifg_q, ifg_n;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] addr_adv;

`ifdef TX_FCS_EN
  logic [31:0] crc_q, crc_n;
  logic [2:0]  fcs_q, fcs_n;
  logic [31:0] fcs_word;
  logic [2:0]  fcs_nxt;

  // One byte of the reflected CRC-32, LSB of the data first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign fcs_word = ~crc_q;
  assign fcs_nxt  = fcs_q + 3'd1;
`endif

  assign last_idx = len_q - ADDR_W'(1);
  // Address stops at the last byte so the read never leaves the frame.
  assign addr_adv = (addr_q < last_idx) ? addr_q + ADDR_W'(1) : addr_q;

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    addr_n  = addr_q;
    byte_n  = byte_q;
    phase_n = phase_q;
    pf_n    = pf_q;
    data_n  = data_q;
    txd_n   = txd_q;
    txen_n  = txen_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    ifg_n   = ifg_q;
`ifdef TX_FCS_EN
    crc_n   = crc_q;
    fcs_n   = fcs_q;
`endif
    case (state_q)
      IDLE: begin
        addr_n = '0;
        if (start) begin
          if (frame_len >= LEN_MIN && frame_len <= LEN_MAX) begin
            len_n   = frame_len;
            busy_n  = 1'b1;
            pf_n    = 1'b0;
            state_n = PREFETCH;
`ifdef TX_FCS_EN
            crc_n   = 32'hFFFFFFFF;
`endif
          end else begin
            err_n = 1'b1;
          end
        end
      end
      PREFETCH: begin
        // Byte 0 arrives now; byte 1 is requested one edge earlier so it
        // is ready for the first high-nibble edge.
        if (!pf_q) begin
          pf_n   = 1'b1;
          addr_n = addr_adv;
        end else begin
          state_n = DATA;
          txen_n  = 1'b1;
          txd_n   = ram_dout[3:0];
          data_n  = ram_dout;
          phase_n = 1'b0;
          byte_n  = '0;
        end
      end
      DATA: begin
        if (!phase_q) begin
          txd_n   = data_q[7:4];
          data_n  = ram_dout;
          phase_n = 1'b1;
          addr_n  = addr_adv;
`ifdef TX_FCS_EN
          if (byte_q >= ADDR_W'(8))
            crc_n = crc_byte(crc_q, data_q);
`endif
        end else if (byte_q == last_idx) begin
`ifdef TX_FCS_EN
          state_n = FCS;
          fcs_n   = 3'd0;
          txd_n   = fcs_word[3:0];
`else
          state_n = IFG;
          ifg_n   = '0;
          txen_n  = 1'b0;
          txd_n   = 4'h0;
`endif
        end else begin
          byte_n  = byte_q + ADDR_W'(1);
          phase_n = 1'b0;
          txd_n   = data_q[3:0];
        end
      end
`ifdef TX_FCS_EN
      FCS: begin
        if (fcs_q == 3'd7) begin
          state_n = IFG;
          ifg_n   = '0;
          txen_n  = 1'b0;
          txd_n   = 4'h0;
        end else begin
          fcs_n = fcs_nxt;
          txd_n = fcs_word[{fcs_nxt, 2'b00} +: 4];
        end
      end
`endif
      IFG: begin
        if (ifg_q == IFG_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          ifg_n = ifg_q + IFG_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      phase_q <= 1'b0;
      pf_q    <= 1'b0;
      data_q  <= '0;
      txd_q   <= '0;
      txen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ifg_q   <= '0;
`ifdef TX_FCS_EN
      crc_q   <= 32'hFFFFFFFF;
      fcs_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      len_q   <= len_n;
      addr_q  <= addr_n;
      byte_q  <= byte_n;
      phase_q <= phase_n;
      pf_q    <= pf_n;
      data_q  <= data_n;
      txd_q   <= txd_n;
      txen_q  <= txen_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      ifg_q   <= ifg_n;
`ifdef TX_FCS_EN
      crc_q   <= crc_n;
      fcs_q   <= fcs_n;
`endif
    end
  end

  assign ram_addr = addr_q;
  assign tx_d     = txd_q;
  assign tx_en    = txen_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_frame_tx_mii.sv
// tb_frame_tx_mii: directed bench with a nibble scoreboard for frame_tx_mii.
module tb_frame_tx_mii;
  localparam int ADDR_W    = 11;
  localparam int IFG_BYTES = 12;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [ADDR_W-1:0] frame_len, ram_addr;
  logic [7:0]        ram_dout;
  logic [3:0]        tx_d;
  logic              tx_en, busy, done, err;

  always #20 clk = ~clk;

  frame_tx_mii #(.ADDR_W(ADDR_W), .IFG_BYTES(IFG_BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .tx_d(tx_d), .tx_en(tx_en),
    .busy(busy), .done(done), .err(err)
  );

  // Synchronous frame buffer, one clk read latency.
  logic [7:0] mem [0:2047];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: captures transmitted nibbles and timing markers.
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];
  int   en_total = 0, runs_total = 0, first_en = 0, last_en = 0;
  int   done_total = 0, last_done = 0, zero_viol = 0;
  logic prev_en = 1'b0, busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      en_total <= en_total + 1;
      got_q.push_back(tx_d);
      if (prev_en !== 1'b1) begin
        runs_total <= runs_total + 1;
        first_en   <= cyc;
      end
      last_en <= cyc;
    end else if (tx_en === 1'b0 && tx_d !== 4'h0) begin
      zero_viol <= zero_viol + 1;
    end
    prev_en <= tx_en;
    if (done === 1'b1) begin
      done_total   <= done_total + 1;
      last_done    <= cyc;
      busy_at_done <= busy;
    end
  end

  int cmp_n = 0, err_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fcs(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < len; i++) begin
      c = c ^ {24'h0, mem[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int exp_en(input int len);
`ifdef TX_FCS_EN
    return 2 * len + 8;
`else
    return 2 * len;
`endif
  endfunction

  task automatic push_exp(input int len);
    logic [7:0]  b;
    logic [31:0] f;
    for (int i = 0; i < len; i++) begin
      b = mem[i];
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
    end
    f = ref_fcs(len);
`ifdef TX_FCS_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(f[4*k +: 4]);
`endif
  endtask

  task automatic check_nibbles(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (done_total > base) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_frame(input int len, input bit poke);
    int eb, rb, db, p;
    bit ok;
    eb = en_total; rb = runs_total; db = done_total;
    push_exp(len);
    @(posedge clk); #1;
    p = cyc; start = 1'b1; frame_len = ADDR_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (10) @(posedge clk);
      #1; start = 1'b1; frame_len = ADDR_W'(20);
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done(db, ok);
    chk("done_seen", ok, 1);
    chk("first_en", first_en, p + 3);
    chk("en_cycles", en_total - eb, exp_en(len));
    chk("en_runs", runs_total - rb, 1);
    chk("ifg_len", last_done - last_en, 2 * IFG_BYTES);
    chk("busy_at_done", busy_at_done, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    check_nibbles("nibble");
  endtask

  task automatic bad_start(input int len);
    @(posedge clk); #1;
    start = 1'b1; frame_len = ADDR_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    @(posedge clk); #1;
    chk("bad_err_pulse", err, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("bad_tx_en", tx_en, 0);
    chk("bad_busy_late", busy, 0);
  endtask

  initial begin
    logic [71:0] digits;
    int eb, rb, db, d;
    bit ok;
    digits = "123456789";
    rst = 1'b1; start = 1'b0; frame_len = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) mem[i] = 8'h55;
    mem[7] = 8'hD5;
    for (int i = 0; i < 9; i++) mem[8 + i] = digits[8 * (8 - i) +: 8];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_d", tx_d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", ram_addr, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1; frame_len = ADDR_W'(17);
    @(posedge clk); #1;
    chk("rst_prio_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio_busy2", busy, 0);
    chk("rst_prio_tx_en", tx_en, 0);

    run_frame(17, 1'b0);
    run_frame(17, 1'b1);
    bad_start(8);
    bad_start(1402);
    run_frame(9, 1'b0);
    run_frame(64, 1'b0);
    run_frame(1401, 1'b0);

    // Reset on the 20th transmitted nibble truncates the frame.
    eb = en_total; db = done_total;
    @(posedge clk); #1;
    start = 1'b1; frame_len = ADDR_W'(17);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (en_total - eb >= 20) break;
    end
    chk("mid_rst_reach", en_total - eb, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_tx_d", tx_d, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", ram_addr, 0);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_total - db, 0);
    chk("mid_rst_idle", tx_en, 0);
    got_q.delete();
    exp_q.delete();
    run_frame(17, 1'b0);

    // start held high: one frame, then the next begins 3 cycles after done.
    eb = en_total; rb = runs_total; db = done_total;
    push_exp(17);
    push_exp(17);
    @(posedge clk); #1;
    start = 1'b1; frame_len = ADDR_W'(17);
    wait_done(db, ok);
    chk("held_done1", ok, 1);
    d = last_done;
    chk("held_runs1", runs_total - rb, 1);
    chk("held_en1", en_total - eb, exp_en(17));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (runs_total - rb >= 2) break;
    end
    chk("held_restart", first_en, d + 3);
    start = 1'b0;
    wait_done(db + 1, ok);
    chk("held_done2", ok, 1);
    chk("held_en2", en_total - eb, 2 * exp_en(17));
    check_nibbles("held_nibble");

    chk("txd_zero_idle", zero_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
